// File: rtl/i2c_cfg_pkg.sv
// Shared types and the boot-time register table for the I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAIL      = 3'd7
  } seq_state_e;

  localparam int TABLE_DEPTH = 16;

  localparam cfg_entry_t DEFAULT_TABLE [TABLE_DEPTH] = '{
    '{reg_addr: 8'h0F, data: 8'h80}, '{reg_addr: 8'h10, data: 8'h3C},
    '{reg_addr: 8'h11, data: 8'h5A}, '{reg_addr: 8'h12, data: 8'hA5},
    '{reg_addr: 8'h13, data: 8'h01}, '{reg_addr: 8'h14, data: 8'hFF},
    '{reg_addr: 8'h15, data: 8'h7E}, '{reg_addr: 8'h16, data: 8'h42},
    '{reg_addr: 8'h20, data: 8'h00}, '{reg_addr: 8'h21, data: 8'h11},
    '{reg_addr: 8'h22, data: 8'h22}, '{reg_addr: 8'h23, data: 8'h33},
    '{reg_addr: 8'h30, data: 8'hC0}, '{reg_addr: 8'h31, data: 8'hDE},
    '{reg_addr: 8'h32, data: 8'hAD}, '{reg_addr: 8'h3F, data: 8'h01}
  };

  // Counter widths never collapse to zero bits, even for single-value ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Combinational lookup of one configuration entry; indices past the table read as zero.
module i2c_config_rom import i2c_cfg_pkg::*; #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = clog2_min1(NUM_ENTRIES)
) (
  input  logic [IDX_W-1:0] index_i,
  output cfg_entry_t       entry_o
);

  always_comb begin
    entry_o = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (i < NUM_ENTRIES && index_i == IDX_W'(i)) begin
        entry_o = DEFAULT_TABLE[i];
      end
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the configuration table through the I2C write master, retrying NACKed or
// timed-out writes, and reports aggregate done/fail status.
module i2c_config_sequencer import i2c_cfg_pkg::*; #(
  parameter int         NUM_ENTRIES    = 16,
  parameter logic [6:0] SLAVE_ADDR     = 7'h1A,
  parameter int         MAX_RETRIES    = 3,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 64,
  localparam int        IDX_W          = clog2_min1(NUM_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [IDX_W-1:0] fail_index_o,
  output logic [6:0]       m_slav_addr_o,
  output logic             m_read_not_write_o,
  output logic [7:0]       m_reg_addr_o,
  output logic [7:0]       m_write_data_o,
  output logic             m_write_valid_o,
  input  logic             m_write_ready_i,
  input  logic             m_error_i
);

  localparam int RTY_W = clog2_min1(MAX_RETRIES + 1);
  localparam int TMR_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = clog2_min1(GAP_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;
  logic             fail_q, fail_d;
  logic [IDX_W-1:0] fail_index_q, fail_index_d;
  cfg_entry_t       entry;

  i2c_config_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_rom (
    .index_i (index_q),
    .entry_o (entry)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    err_d        = err_q;
    fail_d       = fail_q;
    fail_index_d = fail_index_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          index_d = '0;
          retry_d = '0;
          fail_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      // valid is held in ISSUE, so ready alone completes the handshake
      ST_ISSUE: begin
        if (m_write_ready_i) begin
          timer_d = '0;
          err_d   = 1'b0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
        if (state_q == ST_WAIT_BUSY && !m_write_ready_i) begin
          state_d = ST_WAIT_DONE;
        end else if (state_q == ST_WAIT_DONE && m_write_ready_i) begin
          // the master drops its NACK flag one cycle after ready returns
          err_d   = m_error_i;
          state_d = ST_CHECK;
        end else if (timer_q == TMR_MAX) begin
          err_d   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        gap_d = '0;
        if (!err_q) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            retry_d = '0;
            state_d = ST_GAP;
          end
        end else if (retry_q < RTY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_GAP;
        end else begin
          fail_d       = 1'b1;
          fail_index_d = index_q;
          state_d      = ST_FAIL;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_ISSUE;
        else                   gap_d   = gap_q + 1'b1;
      end
      ST_DONE, ST_FAIL: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      err_q        <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      err_q        <= err_d;
      fail_q       <= fail_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = (state_q == ST_DONE);
  assign fail_o             = fail_q;
  assign fail_index_o       = fail_index_q;
  assign m_slav_addr_o      = SLAVE_ADDR;
  assign m_read_not_write_o = 1'b0;
  assign m_reg_addr_o       = entry.reg_addr;
  assign m_write_data_o     = entry.data;
  assign m_write_valid_o    = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench: a small I2C write-master model logs every handshake and can NACK or stall.
module tb_i2c_config_sequencer;

  localparam int N        = 4;
  localparam int BUSY_NOM = 5;
  // handshake-to-handshake: WAIT_BUSY 1 + WAIT_DONE 5 + CHECK 1 + GAP 4 + ISSUE 1
  localparam int SPACING  = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fail, rnw, wrValid;
  logic [1:0] failIndex;
  logic [6:0] slavAddr;
  logic [7:0] regAddr, wrData;
  logic       wrReady = 1'b1;
  logic       mError = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2c_config_sequencer #(
    .NUM_ENTRIES    (N),
    .SLAVE_ADDR     (7'h1A),
    .MAX_RETRIES    (3),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .busy_o             (busy),
    .done_o             (done),
    .fail_o             (fail),
    .fail_index_o       (failIndex),
    .m_slav_addr_o      (slavAddr),
    .m_read_not_write_o (rnw),
    .m_reg_addr_o       (regAddr),
    .m_write_data_o     (wrData),
    .m_write_valid_o    (wrValid),
    .m_write_ready_i    (wrReady),
    .m_error_i          (mError)
  );

  function automatic logic [7:0] expReg(input int i);
    case (i)
      0: return 8'h0F;
      1: return 8'h10;
      2: return 8'h11;
      default: return 8'h12;
    endcase
  endfunction

  function automatic logic [7:0] expData(input int i);
    case (i)
      0: return 8'h80;
      1: return 8'h3C;
      2: return 8'h5A;
      default: return 8'hA5;
    endcase
  endfunction

  // master model configuration (written by the stimulus process only)
  int         busyLen = BUSY_NOM;
  logic [1:0] nackEntry = 2'd0;
  int         nackLimit = 0;

  // master model state and transaction log (written by the model only)
  int         cyc = 0;
  int         doneCount = 0;
  int         nackUsed = 0;
  int         mCnt = 0;
  logic       mBusy = 1'b0;
  logic       mPendErr = 1'b0;
  logic [7:0] logReg[$];
  logic [7:0] logData[$];
  logic [6:0] logSlave[$];
  int         logCycle[$];

  // the master is never reset by the sequencer, so it keeps running across DUT resets
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) doneCount <= doneCount + 1;
    if (mBusy) begin
      if (mCnt <= 1) begin
        mBusy   <= 1'b0;
        wrReady <= 1'b1;
        mError  <= mPendErr;
      end else begin
        mCnt <= mCnt - 1;
      end
    end else begin
      mError <= 1'b0;
      if (wrValid && wrReady) begin
        logReg.push_back(regAddr);
        logData.push_back(wrData);
        logSlave.push_back(slavAddr);
        logCycle.push_back(cyc);
        mBusy   <= 1'b1;
        mCnt    <= busyLen;
        wrReady <= 1'b0;
        if (nackUsed < nackLimit && regAddr == expReg(int'(nackEntry))) begin
          mPendErr <= 1'b1;
          nackUsed <= nackUsed + 1;
        end else begin
          mPendErr <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    bit prevDone = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (prevDone) checkOutput("busy after done", busy, 0);
      prevDone = done;
      if (!busy) break;
    end
    checkOutput("run finished", busy, 0);
  endtask

  task automatic waitModelIdle(input int budget);
    for (int k = 0; k < budget && mBusy; k++) @(negedge clk);
    checkOutput("master idle", wrReady, 1);
  endtask

  int expSeq[$];

  task automatic checkLog(input int base);
    checkOutput("txn count", logReg.size() - base, expSeq.size());
    for (int i = 0; i < expSeq.size(); i++) begin
      if (base + i < logReg.size()) begin
        checkOutput($sformatf("txn%0d reg", i), logReg[base+i], expReg(expSeq[i]));
        checkOutput($sformatf("txn%0d data", i), logData[base+i], expData(expSeq[i]));
        checkOutput($sformatf("txn%0d slave", i), logSlave[base+i], 7'h1A);
      end
    end
  endtask

  initial begin
    int base;
    int d0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset fail", fail, 0);
    checkOutput("reset valid", wrValid, 0);
    checkOutput("reset fail_index", failIndex, 0);
    checkOutput("slave addr", slavAddr, 7'h1A);
    checkOutput("read_not_write", rnw, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal run
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    checkOutput("busy after start", busy, 1);
    waitIdle(2000);
    expSeq = '{0, 1, 2, 3};
    checkLog(base);
    for (int i = 1; i < N; i++) begin
      if (base + i < logCycle.size())
        checkOutput($sformatf("spacing%0d", i), logCycle[base+i] - logCycle[base+i-1], SPACING);
    end
    checkOutput("nominal done pulses", doneCount - d0, 1);
    checkOutput("nominal fail", fail, 0);

    // single NACK on entry 2
    nackEntry = 2'd2;
    nackLimit = nackUsed + 1;
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    waitIdle(2000);
    expSeq = '{0, 1, 2, 2, 3};
    checkLog(base);
    checkOutput("retry done pulses", doneCount - d0, 1);
    checkOutput("retry fail", fail, 0);

    // entry 1 NACKs on every attempt
    nackEntry = 2'd1;
    nackLimit = nackUsed + 4;
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    waitIdle(2000);
    expSeq = '{0, 1, 1, 1, 1};
    checkLog(base);
    checkOutput("exhaust fail", fail, 1);
    checkOutput("exhaust fail_index", failIndex, 1);
    checkOutput("exhaust done pulses", doneCount - d0, 0);

    // restart after fail, with a second start while busy
    nackLimit = nackUsed;
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    checkOutput("fail cleared by start", fail, 0);
    repeat (20) @(negedge clk);
    applyStimulus();
    waitIdle(2000);
    expSeq = '{0, 1, 2, 3};
    checkLog(base);
    checkOutput("restart done pulses", doneCount - d0, 1);

    // master stalls past the timeout on every attempt
    busyLen = 100;
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    waitIdle(3000);
    expSeq = '{0, 0, 0, 0};
    checkLog(base);
    checkOutput("timeout fail", fail, 1);
    checkOutput("timeout fail_index", failIndex, 0);
    checkOutput("timeout done pulses", doneCount - d0, 0);
    busyLen = BUSY_NOM;
    waitModelIdle(300);

    // reset while waiting for the master to finish
    busyLen = 20;
    base = logReg.size();
    d0 = doneCount;
    applyStimulus();
    for (int k = 0; k < 50 && logReg.size() == base; k++) @(negedge clk);
    checkOutput("first handshake seen", logReg.size() - base, 1);
    busyLen = BUSY_NOM;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset valid", wrValid, 0);
    checkOutput("mid reset fail", fail, 0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("valid while master busy", wrValid, 1);
    checkOutput("no handshake while busy", logReg.size() - base, 1);
    waitIdle(2000);
    expSeq = '{0, 0, 1, 2, 3};
    checkLog(base);
    if (base + 1 < logCycle.size())
      checkOutput("reissue waits for ready", logCycle[base+1] - logCycle[base], 21);
    checkOutput("post reset done pulses", doneCount - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Boot-time configuration controller that sits in front of the I2C write master.
- Walks a fixed table of (register address, data) writes to one slave device and issues each write through the master's valid/ready interface.
- Detects completion, NACK and timeout per write, and retries failed writes up to a limit.
- Reports aggregate done/fail status to system control logic.

Parameters:
- NUM_ENTRIES, 16: number of table writes, must be ≥1.
- SLAVE_ADDR, 7'h1A: 7-bit target slave address, same for all entries.
- MAX_RETRIES, 3: extra attempts allowed per entry after a NACK or timeout.
- GAP_CYCLES, 4: idle clk cycles between consecutive transactions, must be ≥1.
- TIMEOUT_CYCLES, 64: maximum cycles from handshake to master-ready return.

Ports:
- clk, in, 1: I2C-rate system clock (20 kHz), shared with the master.
- rst_n, in, 1: reset, synchronous and active-low.
- start, in, 1: single-cycle request to run the table; ignored while busy.
- busy, out, 1: high from the cycle after an accepted start until done or fail.
- done, out, 1: single-cycle pulse; all entries written and ACKed.
- fail, out, 1: sticky failure flag; cleared by the next accepted start.
- fail_index, out, $clog2(NUM_ENTRIES): entry that exhausted its retries.
- m_slav_addr, out, 7: to master, constant SLAVE_ADDR.
- m_read_not_write, out, 1: to master, constant 0.
- m_reg_addr, out, 8: to master, register address of the current entry.
- m_write_data, out, 8: to master, data byte of the current entry.
- m_write_valid, out, 1: to master, write request.
- m_write_ready, in, 1: from master, high only when the master is idle.
- m_error, in, 1: from master, NACK flag; valid in the first cycle m_write_ready returns high.

Behaviour:
- Reset values: state IDLE; index, retry count, timer and gap counter 0; busy, done, fail, m_write_valid all 0; fail_index 0.
- Address/data outputs come from the table entry at the current index and stay stable while m_write_valid is high.
- States and transitions:
  - IDLE: start=1 → clear index, retry count and fail; go to ISSUE.
  - ISSUE: m_write_valid=1. When m_write_valid & m_write_ready are high in the same cycle (handshake) → clear timer, go to WAIT_BUSY. m_write_valid is deasserted the following cycle and is low in every state except ISSUE.
  - WAIT_BUSY: wait for m_write_ready=0, then go to WAIT_DONE. The timer runs.
  - WAIT_DONE: wait for m_write_ready=1; in that same cycle sample m_error, then go to CHECK. The timer runs.
  - Timeout: if the timer reaches TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE, treat the attempt as failed and go to CHECK.
  - CHECK, success (no error, no timeout):
    - Last index → DONE.
    - Otherwise increment index, clear retry count, go to GAP.
  - CHECK, failure:
    - Retry count < MAX_RETRIES → increment retry count, go to GAP; the same index is re-issued.
    - Otherwise → FAIL, latch fail_index = index.
  - GAP: count GAP_CYCLES cycles, then go to ISSUE.
  - DONE: done=1 for one cycle → IDLE.
  - FAIL: fail set → IDLE. fail holds until the next accepted start.
- busy is high in every state except IDLE.
- start asserted while busy is ignored.
- The error sample is taken only in the first m_write_ready-high cycle, because the master clears its NACK flags one cycle later.
- Counters saturate and never wrap:
  - index width $clog2(NUM_ENTRIES);
  - retry width $clog2(MAX_RETRIES+1);
  - timer width $clog2(TIMEOUT_CYCLES+1).
- rst_n low mid-transaction returns to IDLE next edge with m_write_valid=0. The master is not reset by this block; the next start waits in ISSUE until m_write_ready=1.
- NUM_ENTRIES=1: DONE follows the first successful CHECK with no GAP.

Decomposition:
- Package i2c_cfg_pkg:
  - cfg_entry_t struct {reg_addr[7:0], data[7:0]};
  - sequencer state enum;
  - default table constant array.
- Sub-module i2c_config_rom: combinational index → cfg_entry_t lookup, parameterised by NUM_ENTRIES, content from the package.
- The sequencer holds the FSM and all counters.

Test Plan:
- Nominal, NUM_ENTRIES=4 against an ACKing slave model, pulse start → four transactions in table order at slave 0x1A, each preceded by GAP_CYCLES idle cycles, one done pulse, fail=0, busy low the cycle after done.
- Single NACK on entry 2, first attempt → entry 2 re-issued once with identical reg_addr/data, then entries 3..N; done=1, fail=0.
- Entry 1 NACKs on all 4 attempts (MAX_RETRIES=3) → exactly 4 transactions on entry 1, fail=1, fail_index=1, no done, later entries never issued.
- Master model holds m_write_ready low for 100 cycles (TIMEOUT_CYCLES=64) → retries counted as failures; fail=1 after 4 timeouts.
- Start pulsed again while busy → no restart, transaction count unchanged. Start after fail → fail clears the next cycle and the run completes.
- rst_n low for 1 cycle during WAIT_DONE → next cycle IDLE, busy=0, m_write_valid=0. A new start issues entry 0 only once m_write_ready=1.
